key_conditioner: RTL and testbench

//  Input-side companion to the board top level: turns raw, bouncing, asynchronous,

---
 rtl/key_conditioner.sv | 132 +++++++++++++
 tb/tb_key_conditioner.sv | 116 +++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounces active-low KEY pins into clean press levels and press/release pulses
module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              any_pressed
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_pressed;
        logic             r_press_pulse;
        logic             r_release_pulse;
        logic             w_pressed_nxt;
        logic             w_press_nxt;
        logic             w_release_nxt;
        logic             w_cnt_done;
        logic             w_key_down;

        // Synchronizer idles at 1 so a key held through reset is seen as a fresh press.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= key_n[gi];
                r_sync2 <= r_sync1;
            end
        end

        assign w_key_down = ~r_sync2;
        assign w_cnt_done = (r_cnt == CNT_LAST);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state         <= ST_RELEASED;
                r_cnt           <= '0;
                r_pressed       <= 1'b0;
                r_press_pulse   <= 1'b0;
                r_release_pulse <= 1'b0;
            end else begin
                r_state         <= w_state_nxt;
                r_cnt           <= w_cnt_nxt;
                r_pressed       <= w_pressed_nxt;
                r_press_pulse   <= w_press_nxt;
                r_release_pulse <= w_release_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            unique case (r_state)
                ST_RELEASED: begin
                    if (w_key_down) begin
                        w_state_nxt = ST_PRESS_CHK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!w_key_down) begin
                        w_state_nxt = ST_RELEASED;
                    end else if (w_cnt_done) begin
                        w_state_nxt = ST_PRESSED;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!w_key_down) begin
                        w_state_nxt = ST_RELEASE_CHK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RELEASE_CHK: begin
                    if (w_key_down) begin
                        w_state_nxt = ST_PRESSED;
                    end else if (w_cnt_done) begin
                        w_state_nxt = ST_RELEASED;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Pulses are mutually exclusive because they come from different check states.
        always_comb begin
            w_press_nxt   = (r_state == ST_PRESS_CHK) && w_key_down && w_cnt_done;
            w_release_nxt = (r_state == ST_RELEASE_CHK) && !w_key_down && w_cnt_done;
            w_pressed_nxt = r_pressed;
            if (w_press_nxt) begin
                w_pressed_nxt = 1'b1;
            end else if (w_release_nxt) begin
                w_pressed_nxt = 1'b0;
            end
        end

        assign pressed[gi]       = r_pressed;
        assign press_pulse[gi]   = r_press_pulse;
        assign release_pulse[gi] = r_release_pulse;
    end

    assign any_pressed = |pressed;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed table-driven bench for key_conditioner
`timescale 1ns/1ps
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_n;
    logic [3:0] pressed;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       any_pressed;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] key;
        logic [3:0] pr;
        logic [3:0] pp;
        logic [3:0] rp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    key_conditioner #(.N_KEYS(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_n         (key_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .any_pressed   (any_pressed)
    );

    task automatic add(input int n, input logic [3:0] key, input logic [3:0] pr,
                       input logic [3:0] pp, input logic [3:0] rp);
        vec_t v;
        v.key = key; v.pr = pr; v.pp = pp; v.rp = rp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] pr,
                         input logic [3:0] pp, input logic [3:0] rp, input logic any);
        n_checks++;
        if ({pressed, press_pulse, release_pulse, any_pressed} !== {pr, pp, rp, any}) begin
            n_errors++;
            $display("FAIL %s[%0d]: got pressed=%b press=%b release=%b any=%b, expected pressed=%b press=%b release=%b any=%b",
                     name, idx, pressed, press_pulse, release_pulse, any_pressed, pr, pp, rp, any);
        end
    endtask

    initial begin
        // clean press key0
        add(6, 4'hE, 4'h0, 4'h0, 4'h0);
        add(1, 4'hE, 4'h1, 4'h1, 4'h0);
        add(1, 4'hE, 4'h1, 4'h0, 4'h0);
        // key1 bounce: low 3, high 1, low 10
        add(3, 4'hC, 4'h1, 4'h0, 4'h0);
        add(1, 4'hE, 4'h1, 4'h0, 4'h0);
        add(6, 4'hC, 4'h1, 4'h0, 4'h0);
        add(1, 4'hC, 4'h3, 4'h2, 4'h0);
        add(3, 4'hC, 4'h3, 4'h0, 4'h0);
        // release key0
        add(6, 4'hD, 4'h3, 4'h0, 4'h0);
        add(1, 4'hD, 4'h2, 4'h0, 4'h1);
        add(1, 4'hD, 4'h2, 4'h0, 4'h0);
        // release key1
        add(6, 4'hF, 4'h2, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 4'h0, 4'h2);
        add(1, 4'hF, 4'h0, 4'h0, 4'h0);
        // simultaneous keys 1 and 3
        add(6, 4'h5, 4'h0, 4'h0, 4'h0);
        add(1, 4'h5, 4'hA, 4'hA, 4'h0);
        add(1, 4'h5, 4'hA, 4'h0, 4'h0);
        // press key2, then 2-cycle release glitch
        add(6, 4'h1, 4'hA, 4'h0, 4'h0);
        add(1, 4'h1, 4'hE, 4'h4, 4'h0);
        add(1, 4'h1, 4'hE, 4'h0, 4'h0);
        add(2, 4'h5, 4'hE, 4'h0, 4'h0);
        add(8, 4'h1, 4'hE, 4'h0, 4'h0);

        reset_n = 1'b0;
        key_n   = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_state", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            key_n = vecs[i].key;
            @(negedge clk);
            check("vec", i, vecs[i].pr, vecs[i].pp, vecs[i].rp, |vecs[i].pr);
        end

        // asynchronous reset with all keys held, then requalification
        key_n   = 4'h0;
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("in_reset", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e < 7)       check("post_reset", e, 4'h0, 4'h0, 4'h0, 1'b0);
            else if (e == 7) check("post_reset", e, 4'hF, 4'hF, 4'h0, 1'b1);
            else             check("post_reset", e, 4'hF, 4'h0, 4'h0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
